bip_control: RTL

Instruction fetch/decode control unit for the BIP1 processor, directly upstream of the accumulator datapath.
- Holds the PC and reads program memory.
- Decodes each 16-bit instruction (opcode[15:11], operand[10:0]) into the datapath selects (SelA, SelB, WrAcc, op), the operand and the data-memory strobes.
- Stops on HLT and counts executed clock cycles for the debug unit.

---
 rtl/bip_control_if.sv | 30 +++
 rtl/bip_control.sv | 123 ++++++++++++
 2 files changed

// File: rtl/bip_control_if.sv
// rtl/bip_control_if.sv - BIP1 control unit bus: program-memory fetch and datapath/data-memory controls
interface bip_control_if #(
   parameter int NB_DATA    = 16,
   parameter int NB_OPERAND = 11,
   parameter int NB_ADDR    = 11,
   parameter int NB_CYCLES  = 32
);
   logic [NB_ADDR-1:0]    pc_addr;
   logic                  rd_instr;
   logic [NB_DATA-1:0]    instruction;
   logic [1:0]            sel_a;
   logic                  sel_b;
   logic                  wr_acc;
   logic                  op;
   logic [NB_OPERAND-1:0] operand;
   logic                  wr_ram;
   logic                  rd_ram;
   logic                  halt;
   logic [NB_CYCLES-1:0]  cycle_count;

   modport master (
      output pc_addr, rd_instr, sel_a, sel_b, wr_acc, op, operand, wr_ram, rd_ram, halt, cycle_count,
      input  instruction
   );

   modport slave (
      input  pc_addr, rd_instr, sel_a, sel_b, wr_acc, op, operand, wr_ram, rd_ram, halt, cycle_count,
      output instruction
   );
endinterface

// File: rtl/bip_control.sv
// rtl/bip_control.sv - BIP1 fetch/decode control unit with PC, HLT stop and saturating cycle counter
// Optional: define BIP_CTRL_ILLEGAL_HALT_EN to halt on opcodes 01000-11111 instead of treating them as NOP.
module bip_control #(
   parameter int NB_DATA    = 16,
   parameter int NB_OPCODE  = 5,
   parameter int NB_OPERAND = 11,
   parameter int NB_ADDR    = 11,
   parameter int NB_CYCLES  = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   bip_control_if.master   bus
);
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

   localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
   localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
   localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
   localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
   localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
   localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
   localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
   localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

   state_t                 state;
   logic [NB_ADDR-1:0]     pc;
   logic                   rd_instr;
   logic                   halt;
   logic [NB_CYCLES-1:0]   cycle_count;
   logic [NB_OPCODE-1:0]   opcode;
   logic                   stop;
   logic [1:0]             sel_a;
   logic                   sel_b;
   logic                   wr_acc;
   logic                   op;
   logic                   wr_ram;
   logic                   rd_ram;
   logic [NB_OPERAND-1:0]  operand;

   assign opcode = bus.instruction[NB_DATA-1 -: NB_OPCODE];

   // Decode must be combinational: the instruction only becomes valid in EXEC.
   always_comb begin
      sel_a   = 2'b00;
      sel_b   = 1'b0;
      wr_acc  = 1'b0;
      op      = 1'b0;
      wr_ram  = 1'b0;
      rd_ram  = 1'b0;
      operand = '0;
      stop    = 1'b0;
      if (state == EXEC) begin
         operand = bus.instruction[NB_OPERAND-1:0];
         case (opcode)
            OP_HLT:  stop = 1'b1;
            OP_STO:  wr_ram = 1'b1;
            OP_LD:   begin sel_a = 2'b00; rd_ram = 1'b1; wr_acc = 1'b1; end
            OP_LDI:  begin sel_a = 2'b01; wr_acc = 1'b1; end
            OP_ADD:  begin sel_a = 2'b10; rd_ram = 1'b1; wr_acc = 1'b1; end
            OP_ADDI: begin sel_a = 2'b10; sel_b = 1'b1; wr_acc = 1'b1; end
            OP_SUB:  begin sel_a = 2'b10; op = 1'b1; rd_ram = 1'b1; wr_acc = 1'b1; end
            OP_SUBI: begin sel_a = 2'b10; sel_b = 1'b1; op = 1'b1; wr_acc = 1'b1; end
            default: begin
`ifdef BIP_CTRL_ILLEGAL_HALT_EN
               stop = 1'b1;
`else
               stop = 1'b0;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= IDLE;
         pc          <= '0;
         rd_instr    <= 1'b0;
         halt        <= 1'b0;
         cycle_count <= '0;
      end else begin
         if ((state == FETCH || state == EXEC) && cycle_count != {NB_CYCLES{1'b1}})
            cycle_count <= cycle_count + NB_CYCLES'(1);
         case (state)
            IDLE: begin
               if (i_start) begin
                  state    <= FETCH;
                  rd_instr <= 1'b1;
               end
            end
            FETCH: begin
               state    <= EXEC;
               rd_instr <= 1'b0;
            end
            EXEC: begin
               if (stop) begin
                  state <= HALT;
                  halt  <= 1'b1;
               end else begin
                  pc       <= pc + NB_ADDR'(1);
                  state    <= FETCH;
                  rd_instr <= 1'b1;
               end
            end
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.pc_addr     = pc;
   assign bus.rd_instr    = rd_instr;
   assign bus.halt        = halt;
   assign bus.cycle_count = cycle_count;
   assign bus.sel_a       = sel_a;
   assign bus.sel_b       = sel_b;
   assign bus.wr_acc      = wr_acc;
   assign bus.op          = op;
   assign bus.wr_ram      = wr_ram;
   assign bus.rd_ram      = rd_ram;
   assign bus.operand     = operand;
endmodule
